// File: rtl/vga_pixel_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster generator: the default
// 640x480@60 timing, the coordinate type used by the drawing stages, the
// bundle of sync/blank strobes carried through the delay line and the
// constant functions that locate the sync pulses inside a line or frame.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 timing
    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int PIPE_DELAY_DEF = 1;

    // Sync/blank strobes as they travel down the delay line.
    typedef struct packed {
        logic hSyncN;
        logic vSyncN;
        logic blankN;
    } strobes_t;

    // Level every delay stage holds after reset: syncs released, picture blanked.
    localparam strobes_t STROBES_IDLE = '{hSyncN: 1'b1, vSyncN: 1'b1, blankN: 1'b0};

    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count at which the sync pulse is asserted.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Last count at which the sync pulse is asserted (inclusive).
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync - 1;
    endfunction

    localparam int H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_pixel_timing_if.sv
// -----------------------------------------------------------------------------
// vga_pixel_timing_if
// Raster bundle between the timing generator and its consumers.
//   pixelTick     consumer -> generator  pixel-rate enable
//   pixelX/pixelY generator -> consumer  current raster coordinate
//   hSyncN/vSyncN generator -> consumer  delayed sync strobes, active low
//   blankN        generator -> consumer  delayed visible-area flag
//   startOfFrame  generator -> consumer  one-clk pulse at the frame wrap
//   endOfLine     generator -> consumer  one-clk pulse at the line wrap
// -----------------------------------------------------------------------------
interface vga_pixel_timing_if;
    import vga_timing_pkg::*;

    logic   pixelTick;
    coord_t pixelX;
    coord_t pixelY;
    logic   hSyncN;
    logic   vSyncN;
    logic   blankN;
    logic   startOfFrame;
    logic   endOfLine;

    modport master (
        input  pixelTick,
        output pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame, endOfLine
    );

    modport slave (
        output pixelTick,
        input  pixelX, pixelY, hSyncN, vSyncN, blankN, startOfFrame, endOfLine
    );

endinterface

// File: rtl/vga_pixel_timing_sync_delay_line.sv
// -----------------------------------------------------------------------------
// sync_delay_line
// DEPTH-stage shift register with clock enable, used to line the sync/blank
// strobes up with the registered colour returned by the drawing stages.
//   clk     in   clock
//   resetN  in   synchronous active-low reset, loads RESET_VAL into every stage
//   en      in   advance enable (pixel tick)
//   din     in   WIDTH-bit input vector
//   dout    out  din delayed by DEPTH enabled cycles; din itself when DEPTH=0
// -----------------------------------------------------------------------------
module sync_delay_line #(
    parameter int                DEPTH     = 1,
    parameter int                WIDTH     = 3,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // At least one register slot is kept so the array is never empty; with
    // DEPTH=0 it is simply bypassed.
    localparam int NREG = (DEPTH == 0) ? 1 : DEPTH;

    logic [WIDTH-1:0] dly_p [NREG];

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NREG; i++) begin
                dly_p[i] <= RESET_VAL;
            end
        end else if (en) begin
            dly_p[0] <= din;
            for (int i = 1; i < NREG; i++) begin
                dly_p[i] <= dly_p[i-1];
            end
        end
    end

    assign dout = (DEPTH == 0) ? din : dly_p[NREG-1];

endmodule

// File: rtl/vga_pixel_timing.sv
// -----------------------------------------------------------------------------
// vga_pixel_timing
// 640x480@60 (by default) VGA raster generator. Counts pixels and lines at the
// pixelTick rate, decodes the raw sync/blank strobes from the counters and
// delays them by PIPE_DELAY ticks so they stay aligned with the colour that
// the drawing stages return one or more ticks later.
//   clk     in   system clock
//   resetN  in   synchronous active-low reset
//   vga     master side of vga_pixel_timing_if (pixelTick in; coordinates,
//           delayed strobes and line/frame pulses out)
// -----------------------------------------------------------------------------
module vga_pixel_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input logic                clk,
    input logic                resetN,
    vga_pixel_timing_if.master vga
);

    localparam int     H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(sync_start(H_ACTIVE, H_FP));
    localparam coord_t HS_LAST  = coord_t'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam coord_t VS_FIRST = coord_t'(sync_start(V_ACTIVE, V_FP));
    localparam coord_t VS_LAST  = coord_t'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    coord_t   hCount;
    coord_t   vCount;
    logic     lineWrap;
    logic     frameWrap;
    logic     endOfLine_r;
    logic     startOfFrame_r;
    strobes_t rawStrobes;
    strobes_t dlyStrobes;

    assign lineWrap  = (hCount == H_LAST);
    assign frameWrap = lineWrap && (vCount == V_LAST);

    // Stage p0: raster counters and wrap pulses
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hCount         <= '0;
            vCount         <= '0;
            endOfLine_r    <= 1'b0;
            startOfFrame_r <= 1'b0;
        end else begin
            // Pulses are set only on the consuming edge, so a held tick
            // (pixelTick=0 at the wrap point) cannot produce a second pulse.
            endOfLine_r    <= vga.pixelTick && lineWrap;
            startOfFrame_r <= vga.pixelTick && frameWrap;
            if (vga.pixelTick) begin
                if (lineWrap) begin
                    hCount <= '0;
                    if (vCount == V_LAST) begin
                        vCount <= '0;
                    end else begin
                        vCount <= vCount + 1'b1;
                    end
                end else begin
                    hCount <= hCount + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rawStrobes        = STROBES_IDLE;
        rawStrobes.hSyncN = !((hCount >= HS_FIRST) && (hCount <= HS_LAST));
        rawStrobes.vSyncN = !((vCount >= VS_FIRST) && (vCount <= VS_LAST));
        rawStrobes.blankN = (hCount < H_VIS) && (vCount < V_VIS);
    end

    // Stage p1..pN: strobe alignment with the drawing pipeline
    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     ($bits(strobes_t)),
        .RESET_VAL (STROBES_IDLE)
    ) u_sync_delay_line (
        .clk    (clk),
        .resetN (resetN),
        .en     (vga.pixelTick),
        .din    (rawStrobes),
        .dout   (dlyStrobes)
    );

    assign vga.pixelX       = hCount;
    assign vga.pixelY       = vCount;
    assign vga.hSyncN       = dlyStrobes.hSyncN;
    assign vga.vSyncN       = dlyStrobes.vSyncN;
    assign vga.blankN       = dlyStrobes.blankN;
    assign vga.endOfLine    = endOfLine_r;
    assign vga.startOfFrame = startOfFrame_r;

endmodule

// File: tb/tb_vga_pixel_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_timing
// Three builds of vga_pixel_timing share clock, reset and pixelTick:
//   u_def  default 640x480 timing, PIPE_DELAY=1
//   u_s0   miniature 16x8 raster, PIPE_DELAY=0
//   u_s3   miniature 16x8 raster, PIPE_DELAY=3
// The miniature raster (H 8/2/3/3, V 4/1/2/1) makes whole frames short.
// -----------------------------------------------------------------------------
module tb_vga_pixel_timing;

    logic clk;
    logic resetN;
    logic tick;

    int checks;
    int errors;
    int N;            // pixel ticks consumed since the last reset
    logic last_tick;  // previous clk consumed a tick (pulses are set on it)

    vga_pixel_timing_if if_def ();
    vga_pixel_timing_if if_s0 ();
    vga_pixel_timing_if if_s3 ();

    assign if_def.pixelTick = tick;
    assign if_s0.pixelTick  = tick;
    assign if_s3.pixelTick  = tick;

    vga_pixel_timing u_def (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_def)
    );

    vga_pixel_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(0)
    ) u_s0 (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_s0)
    );

    vga_pixel_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(3)
    ) u_s3 (
        .clk    (clk),
        .resetN (resetN),
        .vga    (if_s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at tick %0d: got %0d expected %0d", tag, N, act, exp);
        end
    endtask

    // Expected {hSyncN, vSyncN, blankN} after n ticks with d ticks of delay.
    function automatic logic [2:0] exp_strb(input int n, input int d,
                                            input int ha, input int hf, input int hs, input int ht,
                                            input int va, input int vf, input int vs, input int vt);
        int c;
        int cx;
        int cy;
        logic h;
        logic v;
        logic b;
        c = n - d;
        if (c < 0) return 3'b110;
        cx = c % ht;
        cy = (c / ht) % vt;
        h = !((cx >= ha + hf) && (cx < ha + hf + hs));
        v = !((cy >= va + vf) && (cy < va + vf + vs));
        b = (cx < ha) && (cy < va);
        return {h, v, b};
    endfunction

    task automatic check_small(input string p, input int d, input int x, input int y,
                               input logic hs, input logic vs, input logic bl,
                               input logic eol, input logic sof);
        logic [2:0] e;
        e = exp_strb(N, d, 8, 2, 3, 16, 4, 1, 2, 8);
        chk({p, "_x"}, x, N % 16);
        chk({p, "_y"}, y, (N / 16) % 8);
        chk({p, "_hs"}, int'(hs), int'(e[2]));
        chk({p, "_vs"}, int'(vs), int'(e[1]));
        chk({p, "_blank"}, int'(bl), int'(e[0]));
        chk({p, "_eol"}, int'(eol), int'(last_tick && N > 0 && (N % 16) == 0));
        chk({p, "_sof"}, int'(sof), int'(last_tick && N > 0 && (N % 128) == 0));
    endtask

    task automatic check_all();
        logic [2:0] e;
        e = exp_strb(N, 1, 640, 16, 96, 800, 480, 10, 2, 525);
        chk("def_x", int'(if_def.pixelX), N % 800);
        chk("def_y", int'(if_def.pixelY), (N / 800) % 525);
        chk("def_hs", int'(if_def.hSyncN), int'(e[2]));
        chk("def_vs", int'(if_def.vSyncN), int'(e[1]));
        chk("def_blank", int'(if_def.blankN), int'(e[0]));
        chk("def_eol", int'(if_def.endOfLine), int'(last_tick && N > 0 && (N % 800) == 0));
        chk("def_sof", int'(if_def.startOfFrame), int'(last_tick && N > 0 && (N % 420000) == 0));
        check_small("s0", 0, int'(if_s0.pixelX), int'(if_s0.pixelY), if_s0.hSyncN,
                    if_s0.vSyncN, if_s0.blankN, if_s0.endOfLine, if_s0.startOfFrame);
        check_small("s3", 3, int'(if_s3.pixelX), int'(if_s3.pixelY), if_s3.hSyncN,
                    if_s3.vSyncN, if_s3.blankN, if_s3.endOfLine, if_s3.startOfFrame);
    endtask

    // One clk: drive, let the edge pass, update the tick model, check.
    task automatic clk_cycle(input logic t, input logic r);
        tick   = t;
        resetN = r;
        @(posedge clk);
        #1;
        if (!r) begin
            N         = 0;
            last_tick = 1'b0;
        end else if (t) begin
            N         = N + 1;
            last_tick = 1'b1;
        end else begin
            last_tick = 1'b0;
        end
        check_all();
    endtask

    initial begin
        int hs_low;
        int first_low;
        int eol_cnt;
        int eol_at;
        int sof0_cnt;
        int sof3_cnt;
        int sof0_at;
        int sof3_at;
        int sofd_cnt;
        int f0;
        int f3;

        checks    = 0;
        errors    = 0;
        N         = 0;
        last_tick = 1'b0;
        tick      = 1'b1;
        resetN    = 1'b0;
        @(negedge clk);

        // Reset
        clk_cycle(1'b1, 1'b0);
        clk_cycle(1'b1, 1'b0);
        chk("rst_def_x", int'(if_def.pixelX), 0);
        chk("rst_def_blank", int'(if_def.blankN), 0);
        chk("rst_def_hs", int'(if_def.hSyncN), 1);

        // First line plus a few pixels of the next
        hs_low    = 0;
        first_low = -1;
        eol_cnt   = 0;
        eol_at    = -1;
        for (int i = 1; i <= 810; i++) begin
            clk_cycle(1'b1, 1'b1);
            if (i <= 800 && if_def.hSyncN == 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = N;
            end
            if (if_def.endOfLine) begin
                eol_cnt++;
                eol_at = N;
            end
            if (i == 10) begin
                chk("t10_x", int'(if_def.pixelX), 10);
                chk("t10_blank", int'(if_def.blankN), 1);
            end
        end
        chk("line_hs_low_ticks", hs_low, 96);
        chk("line_hs_first_low", first_low, 657);
        chk("line_eol_count", eol_cnt, 1);
        chk("line_eol_tick", eol_at, 800);
        chk("line_y", int'(if_def.pixelY), 1);

        // pixelTick alternating: 1600 clks, 800 ticks, one line wrap
        eol_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            clk_cycle((i % 2) == 0, 1'b1);
            if (if_def.endOfLine) eol_cnt++;
        end
        chk("tog_x", int'(if_def.pixelX), 10);
        chk("tog_y", int'(if_def.pixelY), 2);
        chk("tog_eol_count", eol_cnt, 1);

        // Mid-frame reset at (300,2)
        for (int i = 0; i < 290; i++) clk_cycle(1'b1, 1'b1);
        chk("pre_rst_x", int'(if_def.pixelX), 300);
        clk_cycle(1'b1, 1'b0);
        chk("mid_rst_x", int'(if_def.pixelX), 0);
        chk("mid_rst_y", int'(if_def.pixelY), 0);
        chk("mid_rst_blank", int'(if_def.blankN), 0);
        chk("mid_rst_vs", int'(if_def.vSyncN), 1);
        chk("mid_rst_eol", int'(if_def.endOfLine), 0);

        // Restart; two miniature frames compare PIPE_DELAY 0 and 3
        sof0_cnt = 0;
        sof3_cnt = 0;
        sof0_at  = -1;
        sof3_at  = -1;
        sofd_cnt = 0;
        f0       = -1;
        f3       = -1;
        for (int i = 0; i < 300; i++) begin
            clk_cycle(1'b1, 1'b1);
            if (if_s0.startOfFrame) begin
                sof0_cnt++;
                if (sof0_at < 0) sof0_at = N;
            end
            if (if_s3.startOfFrame) begin
                sof3_cnt++;
                if (sof3_at < 0) sof3_at = N;
            end
            if (if_def.startOfFrame) sofd_cnt++;
            if (f0 < 0 && if_s0.hSyncN == 1'b0) f0 = N;
            if (f3 < 0 && if_s3.hSyncN == 1'b0) f3 = N;
        end
        chk("resume_x", int'(if_def.pixelX), 300);
        chk("def_no_sof_after_reset", sofd_cnt, 0);
        chk("s0_sof_count", sof0_cnt, 2);
        chk("s3_sof_count", sof3_cnt, 2);
        chk("s0_sof_tick", sof0_at, 128);
        chk("s3_sof_tick", sof3_at, 128);
        chk("s0_hs_first_low", f0, 10);
        chk("s3_hs_first_low", f3, 13);
        chk("hs_shift_3_vs_0", f3 - f0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_timing.md
# vga_pixel_timing

Generates the 640x480@60 VGA raster for the display path. It produces pixelX/pixelY for the drawing stages (background, objects, mux) and the hSyncN/vSyncN/blankN strobes for the DAC/connector. The sync strobes are delayed by a configurable number of pixel ticks so they stay aligned with the registered colour that the drawing stages return.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, pixel ticks of delay on sync/blank outputs; legal range 0..4

Ports:
- clk  in  1  system clock
- resetN  in  1  reset; synchronous, active-low
- pixelTick  in  1  pixel-rate enable; tie high when clk is the pixel clock
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- hSyncN  out  1  horizontal sync, active low, delayed by PIPE_DELAY
- vSyncN  out  1  vertical sync, active low, delayed by PIPE_DELAY
- blankN  out  1  high in the visible area, delayed by PIPE_DELAY
- startOfFrame  out  1  one-clk pulse at the frame wrap
- endOfLine  out  1  one-clk pulse at the line wrap

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- hCount and vCount are 11-bit registers. pixelX and pixelY are these registers driven directly.
- On a clk edge with pixelTick=1:
  - hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - At V_TOTAL-1, vCount wraps to 0.
- With pixelTick=0, all counters and delay registers hold.
- Raw strobes, all derived from the counters:
  - hSync active when H_ACTIVE+H_FP <= hCount <= H_ACTIVE+H_FP+H_SYNC-1, i.e. 656..751.
  - vSync active when V_ACTIVE+V_FP <= vCount <= V_ACTIVE+V_FP+V_SYNC-1, i.e. 490..491.
  - blank active (blankN=0) unless hCount<H_ACTIVE and vCount<V_ACTIVE.
- Delay line: the raw strobes feed a PIPE_DELAY-deep shift register that advances only on pixelTick. With PIPE_DELAY=0 the outputs are the raw combinational strobes.
- endOfLine = 1 for exactly one clk on the edge where hCount goes H_TOTAL-1 -> 0.
- startOfFrame = 1 for exactly one clk on the edge where (hCount,vCount) goes (H_TOTAL-1,V_TOTAL-1) -> (0,0). endOfLine also pulses on that same edge.
- Both pulses are registered and are not delayed by PIPE_DELAY.

## Timing
- Reset values (resetN=0 sampled at a clk edge):
  - hCount=0, vCount=0.
  - Every delay stage holds the inactive level: hSyncN=1, vSyncN=1, blankN=0.
  - startOfFrame=0, endOfLine=0.
- Reset has priority over pixelTick.
- Reset asserted mid-frame restarts the raster at (0,0) on the next edge. No startOfFrame pulse is emitted for that restart.
- Output latency:
  - pixelX/Y change on the same edge that consumes pixelTick.
  - hSyncN/vSyncN/blankN for a coordinate appear PIPE_DELAY ticks after that coordinate is presented.
- The first delayed hSyncN falling edge after reset is at tick 656+PIPE_DELAY.
- Counters are unsigned. No intermediate sum may exceed 11 bits; the default H_TOTAL of 800 fits.

## Structure
- Package vga_timing_pkg holds:
  - default constants (H_/V_ porches, widths, totals)
  - typedef coord_t = logic [10:0]
  - localparam functions computing the sync start and end points
- One sub-module, sync_delay_line:
  - parameterised depth and width (width 3: hSync, vSync, blank)
  - clock enable input = pixelTick
  - reset to a parameterised inactive vector
- The top holds the two counters, the strobe decode and the pulse registers.

## Test plan
- Reset, then pixelTick=1 for 10 clks -> pixelX=10, pixelY=0, hSyncN=1, vSyncN=1, blankN=1 from tick 1 onward.
- Run one line, PIPE_DELAY=1 -> hSyncN low for exactly 96 ticks starting at tick 657. endOfLine pulses once as pixelX goes 799->0 and pixelY goes 0->1.
- Run one full frame -> vSyncN low during lines 490-491 (shifted by 1 tick). startOfFrame pulses once, at the 800*525 = 420000th tick.
- pixelTick toggling 1/0 each clk for 1600 clks -> exactly 800 ticks counted. Outputs frozen on pixelTick=0 cycles. No duplicate endOfLine pulses.
- Assert resetN=0 for 1 clk at (x=300, y=200) -> next edge gives (0,0) with all outputs at reset values. Counting resumes from 0 and no startOfFrame pulse is emitted.
- PIPE_DELAY=0 vs 3 regression -> sync edges shift by exactly 0 vs 3 ticks. pixelX/Y and startOfFrame are identical in both builds.
